// File: rtl/npu_sram_pkg.sv
// Shared definitions for the NPU operand-SRAM stream reader.
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_DEPTH : geometry of the 4096 x 16 SRAM
//   rd_state_t                             : reader control states
package npu_sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 12;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned SRAM_DEPTH  = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/npu_sram_rd_fifo.sv
// Synchronous show-ahead FIFO used as the stream output stage.
// The head entry is visible on data_o whenever empty_o is low.
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i, data_i : write request and data (ignored when full)
//   pop_i          : remove head entry (ignored when empty)
//   data_o         : head entry
//   count_o        : number of stored entries (0..DEPTH)
//   empty_o/full_o : occupancy flags
module npu_sram_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CNT_W'(DEPTH));
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    data_o   = mem_q[rd_ptr_q];
    count_o  = count_q;
  end

  // Storage is cleared on reset so the head output reads zero after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/npu_sram_stream_reader.sv
// Avalon-MM read master for port 2 of the NPU operand SRAM. A start command
// reads `length` words at base_addr, base_addr+stride, ... (modulo the SRAM
// size) and delivers them as a valid/ready stream through a small FIFO.
//   clk, reset              : clock, synchronous active-high reset
//   start/base_addr/stride/length : transfer command, sampled in IDLE
//   busy, done              : transfer in progress / one-cycle completion
//   sram_*                  : SRAM port 2 (read-only use)
//   out_data/out_valid/out_ready/out_last : output stream
// The SRAM returns data the cycle after chipselect; reads are only issued
// when the FIFO has room for every word already requested, so consumer
// backpressure can never overflow the FIFO.
module npu_sram_stream_reader
  import npu_sram_pkg::*;
#(
  parameter int unsigned ADDR_W     = SRAM_ADDR_W,
  parameter int unsigned DATA_W     = SRAM_DATA_W,
  parameter int unsigned LEN_W      = 13,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [1:0]        sram_byteenable,
  output logic [DATA_W-1:0] sram_writedata,
  output logic              sram_clken,
  input  logic [DATA_W-1:0] sram_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  popped_q, popped_d;
  logic              inflight_q, inflight_d;

  logic              issue;
  logic              pop;
  logic [CNT_W:0]    fill;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  npu_sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (inflight_q),
    .data_i  (sram_readdata),
    .pop_i   (pop),
    .data_o  (out_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    // Words held plus the word on its way back from the SRAM.
    fill      = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    issue     = (state_q == RUN) && (issued_q < len_q) &&
                (fill < DEPTH_L) && !fifo_full;
    out_valid = !fifo_empty;
    out_last  = out_valid && (popped_q == len_q - LEN_W'(1));
    pop       = out_valid && out_ready;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    issued_d   = issued_q;
    popped_d   = pop ? popped_q + LEN_W'(1) : popped_q;
    inflight_d = issue;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          stride_d = stride;
          len_d    = length;
          issued_d = '0;
          popped_d = '0;
          state_d  = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + LEN_W'(1);
        end
        if (issued_q == len_q) begin
          state_d = (pop && out_last) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    busy            = (state_q == RUN) || (state_q == DRAIN);
    done            = (state_q == DONE);
    sram_address    = addr_q;
    sram_chipselect = issue;
    sram_write      = 1'b0;
    sram_byteenable = 2'b11;
    sram_writedata  = '0;
    sram_clken      = 1'b1;
  end

endmodule

// File: tb/tb_npu_sram_stream_reader.sv
module tb_npu_sram_stream_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] stride;
  logic [12:0] length;
  logic        busy, done;
  logic [11:0] sram_address;
  logic        sram_chipselect, sram_write, sram_clken;
  logic [1:0]  sram_byteenable;
  logic [15:0] sram_writedata, sram_readdata;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last;

  npu_sram_stream_reader #(
    .ADDR_W     (12),
    .DATA_W     (16),
    .LEN_W      (13),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .stride          (stride),
    .length          (length),
    .busy            (busy),
    .done            (done),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_byteenable (sram_byteenable),
    .sram_writedata  (sram_writedata),
    .sram_clken      (sram_clken),
    .sram_readdata   (sram_readdata),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered address, unregistered output.
  logic [15:0] mem [4096];
  logic [11:0] rd_addr = '0;
  always @(posedge clk) if (sram_chipselect) rd_addr <= sram_address;
  assign sram_readdata = mem[rd_addr];

  int checks = 0;
  int errors = 0;

  int tick = 0;
  int start_tick = 0;
  always @(posedge clk) tick++;

  // 0: always ready, 1: low for relative cycles 2..12, 2: random
  int ready_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       out_ready = !((tick - start_tick) >= 2 && (tick - start_tick) <= 12);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: records what the DUT did, relative to the start cycle.
  bit          mon_en = 0;
  logic [11:0] cs_addr [$];
  int          cs_cyc  [$];
  logic [15:0] got_data [$];
  bit          got_last [$];
  int          got_cyc  [$];
  int done_n, done_cyc, pop_n, rd_before_pop, max_occ, stab_err, bad_last;
  bit busy_seen, valid_seen, stall_prev;
  logic [15:0] stall_data;

  task automatic clear_mon();
    cs_addr.delete(); cs_cyc.delete();
    got_data.delete(); got_last.delete(); got_cyc.delete();
    done_n = 0; done_cyc = -1; pop_n = 0; rd_before_pop = 0; max_occ = 0;
    stab_err = 0; bad_last = 0; busy_seen = 0; valid_seen = 0; stall_prev = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      int rel;
      int occ;
      rel = tick - start_tick;
      if (busy) busy_seen = 1;
      if (out_valid) valid_seen = 1;
      if (sram_chipselect) begin
        cs_addr.push_back(sram_address);
        cs_cyc.push_back(rel);
        if (pop_n == 0) rd_before_pop++;
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(rel);
        pop_n++;
      end
      if (out_last && !out_valid) bad_last++;
      if (done) begin
        done_n++;
        done_cyc = rel;
      end
      if (stall_prev && (!out_valid || out_data !== stall_data)) stab_err++;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      occ = cs_addr.size() - pop_n;
      if (occ > max_occ) max_occ = occ;
    end
  end

  // Reference: word i of a transfer comes from (base + i*stride) mod 4096.
  function automatic logic [11:0] exp_addr(int b, int s, int i);
    return 12'((b + i * s) % 4096);
  endfunction

  task automatic start_xfer(int b, int s, int n);
    @(posedge clk);
    #1;
    clear_mon();
    start_tick = tick;
    mon_en     = 1;
    start      = 1'b1;
    base_addr  = 12'(b);
    stride     = 12'(s);
    length     = 13'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int k;
    for (k = 0; k < 400 && done_n == 0; k++) @(negedge clk);
    if (done_n == 0) begin
      errors++;
      $display("FAIL %s: done timeout, got none required 1", name);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; stride = '0; length = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sram_chipselect, out_valid, out_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {busy, done, sram_chipselect, out_valid, out_last});
    end
    checks++;
    if (sram_address !== 12'h0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: addr %h data %h required 0 0", sram_address, out_data);
    end
    checks++;
    if ({sram_write, sram_byteenable, sram_writedata, sram_clken} !== {1'b0, 2'b11, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL tie_offs: got %b %b %h %b required 0 11 0000 1",
               sram_write, sram_byteenable, sram_writedata, sram_clken);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) mem[16 + i] = 16'h1100 + 16'(i);
    ready_mode = 0;
    start_xfer(16, 1, 4);
    wait_done("basic");
    checks++;
    if (got_data.size() != 4 || cs_addr.size() != 4) begin
      errors++;
      $display("FAIL basic_count: words %0d reads %0d required 4 4", got_data.size(), cs_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] !== 16'h1100 + 16'(i) || got_cyc[i] != 3 + i ||
            got_last[i] != (i == 3) || cs_cyc[i] != 1 + i) begin
          errors++;
          $display("FAIL basic_word%0d: data %h cyc %0d last %0b cs_cyc %0d required %h %0d %0b %0d",
                   i, got_data[i], got_cyc[i], got_last[i], cs_cyc[i],
                   16'h1100 + 16'(i), 3 + i, (i == 3), 1 + i);
        end
      end
    end
    checks++;
    if (done_n != 1 || done_cyc != 7 || !busy_seen) begin
      errors++;
      $display("FAIL basic_done: count %0d cycle %0d busy %0b required 1 7 1", done_n, done_cyc, busy_seen);
    end
  endtask

  task automatic test_wrap_stride();
    int tb_base [2] = '{12'hFFE, 12'h000};
    int tb_str  [2] = '{1, 12'h040};
    int tb_len  [2] = '{4, 3};
    fill_mem_random();
    ready_mode = 0;
    for (int t = 0; t < 2; t++) begin
      start_xfer(tb_base[t], tb_str[t], tb_len[t]);
      wait_done("wrap");
      checks++;
      if (cs_addr.size() != tb_len[t] || got_data.size() != tb_len[t] || done_n != 1) begin
        errors++;
        $display("FAIL wrap%0d_count: reads %0d words %0d done %0d required %0d %0d 1",
                 t, cs_addr.size(), got_data.size(), done_n, tb_len[t], tb_len[t]);
      end else begin
        for (int i = 0; i < tb_len[t]; i++) begin
          logic [11:0] a;
          a = exp_addr(tb_base[t], tb_str[t], i);
          checks++;
          if (cs_addr[i] !== a || got_data[i] !== mem[a]) begin
            errors++;
            $display("FAIL wrap%0d_word%0d: addr %h data %h required %h %h",
                     t, i, cs_addr[i], got_data[i], a, mem[a]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int b;
    b = $urandom_range(0, 4095);
    ready_mode = 1;
    start_xfer(b, 1, 16);
    wait_done("backpressure");
    ready_mode = 0;
    checks++;
    if (rd_before_pop != 4 || max_occ > 4) begin
      errors++;
      $display("FAIL bp_limit: reads_before_pop %0d max_outstanding %0d required 4 <=4", rd_before_pop, max_occ);
    end
    checks++;
    if (got_data.size() != 16 || done_n != 1 || stab_err != 0 || bad_last != 0) begin
      errors++;
      $display("FAIL bp_count: words %0d done %0d unstable %0d stray_last %0d required 16 1 0 0",
               got_data.size(), done_n, stab_err, bad_last);
    end else begin
      for (int i = 0; i < 16; i++) begin
        logic [11:0] a;
        a = exp_addr(b, 1, i);
        checks++;
        if (got_data[i] !== mem[a] || got_last[i] != (i == 15)) begin
          errors++;
          $display("FAIL bp_word%0d: data %h last %0b required %h %0b", i, got_data[i], got_last[i], mem[a], (i == 15));
        end
      end
    end
  endtask

  task automatic test_zero_len();
    ready_mode = 0;
    start_xfer(12'h123, 1, 0);
    wait_done("zero_len");
    checks++;
    if (done_n != 1 || done_cyc != 1 || busy_seen || cs_addr.size() != 0 || valid_seen) begin
      errors++;
      $display("FAIL zero_len: done %0d cyc %0d busy %0b reads %0d valid %0b required 1 1 0 0 0",
               done_n, done_cyc, busy_seen, cs_addr.size(), valid_seen);
    end
  endtask

  task automatic test_ignored_start();
    int b;
    b = $urandom_range(0, 4095);
    ready_mode = 0;
    start_xfer(b, 3, 6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'(b + 100); stride = 12'd7; length = 13'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored_start");
    checks++;
    if (done_n != 1 || done_cyc != 9 || got_data.size() != 6) begin
      errors++;
      $display("FAIL ign_done: done %0d cyc %0d words %0d required 1 9 6", done_n, done_cyc, got_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        logic [11:0] a;
        a = exp_addr(b, 3, i);
        checks++;
        if (cs_addr[i] !== a || got_data[i] !== mem[a] || got_last[i] != (i == 5)) begin
          errors++;
          $display("FAIL ign_word%0d: addr %h data %h last %0b required %h %h %0b",
                   i, cs_addr[i], got_data[i], got_last[i], a, mem[a], (i == 5));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int b;
    ready_mode = 0;
    start_xfer(12'h200, 1, 8);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: valid %b busy %b done %b required 0 0 0", out_valid, busy, done);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (done_n != 0 || valid_seen && got_cyc.size() > 4) begin
      errors++;
      $display("FAIL rst_mid_nodone: done %0d words %0d required 0 <=4", done_n, got_cyc.size());
    end
    b = $urandom_range(0, 4095);
    start_xfer(b, 5, 5);
    wait_done("reset_restart");
    checks++;
    if (done_n != 1 || done_cyc != 8 || got_data.size() != 5) begin
      errors++;
      $display("FAIL rst_restart: done %0d cyc %0d words %0d required 1 8 5", done_n, done_cyc, got_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_data[i] !== mem[exp_addr(b, 5, i)]) begin
          errors++;
          $display("FAIL rst_restart_word%0d: data %h required %h", i, got_data[i], mem[exp_addr(b, 5, i)]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int b, s, n;
      b = $urandom_range(0, 4095);
      s = $urandom_range(0, 4095);
      n = $urandom_range(1, 24);
      ready_mode = 2;
      start_xfer(b, s, n);
      wait_done("random");
      ready_mode = 0;
      checks++;
      if (got_data.size() != n || cs_addr.size() != n || done_n != 1 ||
          max_occ > 4 || stab_err != 0 || bad_last != 0) begin
        errors++;
        $display("FAIL rand%0d_summary: words %0d reads %0d done %0d occ %0d unstable %0d stray_last %0d required %0d %0d 1 <=4 0 0",
                 t, got_data.size(), cs_addr.size(), done_n, max_occ, stab_err, bad_last, n, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          logic [11:0] a;
          a = exp_addr(b, s, i);
          checks++;
          if (cs_addr[i] !== a || got_data[i] !== mem[a] || got_last[i] != (i == n - 1)) begin
            errors++;
            $display("FAIL rand%0d_word%0d: addr %h data %h last %0b required %h %h %0b",
                     t, i, cs_addr[i], got_data[i], got_last[i], a, mem[a], (i == n - 1));
          end
        end
      end
    end
  endtask

  initial begin
    fill_mem_random();
    test_reset();
    test_basic();
    test_wrap_stride();
    test_backpressure();
    test_zero_len();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_sram_stream_reader.md
Name: npu_sram_stream_reader

Overview:
- Avalon-MM read master for port 2 of the 4096 x 16-bit dual-port on-chip SRAM used as NPU operand memory.
- On a start command, issues `length` reads at `base_addr`, `base_addr+stride`, ... and delivers the words as a valid/ready stream to the NPU datapath.
- Absorbs consumer backpressure with a small credit-limited FIFO, because the SRAM has fixed read latency and no waitrequest.

Parameters:
- ADDR_W, 12, SRAM word-address width (4096 words)
- DATA_W, 16, SRAM/stream data width
- LEN_W, 13, transfer-length width (0..4096 words)
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
- clk  in  1  sole clock; SRAM port 2 is clocked by the same clock
- reset  in  1  synchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; latched on accepted start
- stride  in  ADDR_W  address increment, modulo 2^ADDR_W; latched on start
- length  in  LEN_W  number of words; latched on start
- busy  out  1  high from the cycle after accepted start until the cycle done pulses
- done  out  1  one-cycle pulse when the transfer is complete
- sram_address  out  ADDR_W  to SRAM address2
- sram_chipselect  out  1  to SRAM chipselect2; high = read issued this cycle
- sram_write  out  1  to write2; tied 0
- sram_byteenable  out  2  to byteenable2; tied 2'b11
- sram_writedata  out  DATA_W  to writedata2; tied 0
- sram_clken  out  1  to clken2; tied 1
- sram_readdata  in  DATA_W  from readdata2
- out_data  out  DATA_W  stream word (FIFO head)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready; a word transfers when out_valid and out_ready are both high
- out_last  out  1  high with the final word of the transfer

Behaviour:
- Reset values: busy, done, sram_chipselect, out_valid and out_last are 0; sram_address and out_data are 0.
- Reset: the FIFO, the counters and the in-flight flag clear; FSM goes to IDLE.
- Reset mid-transfer aborts the transfer with no done pulse. Read data returning in the cycle after reset is discarded.
- SRAM timing: the address is registered in the SRAM and the output is unregistered.
  - A read issued in cycle T (chipselect=1) returns data on sram_readdata during T+1.
  - The reader pushes that data into the FIFO at the end of T+1.
- In-flight flag = chipselect registered from the previous cycle; at most 1 read is in flight.
- Issue condition: state RUN and issued < len_q and (fifo_count + inflight) < FIFO_DEPTH.
  - This guarantees no FIFO overflow under any out_ready pattern.
- Address:
  - First issue uses base_q.
  - Each issue advances addr <= addr + stride_q, truncated to ADDR_W bits.
  - Wrap from 0xFFF to 0x000 is legal and silent.
- FSM states and transitions:
  - IDLE:
    - start with length != 0: latch base/stride/length, go to RUN.
    - start with length == 0: go to DONE; no SRAM access.
  - RUN: issue reads per the issue condition; when issued == len_q, go to DRAIN.
  - DRAIN: stay until the word with out_last is accepted, then go to DONE.
    - A same-cycle RUN exit is allowed if the last word is accepted immediately.
  - DONE: done = 1 for exactly 1 cycle, busy = 0; go to IDLE.
  - A start in the DONE cycle is ignored.
  - start while busy is ignored; the latched parameters are unaffected.
- out_last is high when the FIFO head is word number len_q-1. It is tracked by a popped-count compare against len_q-1.
- Latency with out_ready held high:
  - start in cycle 0 (IDLE): first sram_chipselect in cycle 1, first out_valid in cycle 3.
  - Throughput is 1 word/cycle.
  - For length N: last word in cycle N+2, done in cycle N+3.
- Simultaneous FIFO push and pop when full is impossible by construction. Push and pop in the same cycle at any other count leaves count unchanged.
- out_data holds stable while out_valid is high and out_ready is low.

Decomposition:
- Package npu_sram_pkg holds:
  - SRAM_ADDR_W = 12, SRAM_DATA_W = 16, SRAM_DEPTH = 4096
  - the FSM state enum {IDLE, RUN, DRAIN, DONE}
- One sub-module, npu_sram_rd_fifo: synchronous show-ahead FIFO with parameter DEPTH and outputs count, empty, full. It serves as the stream output stage.

Test Plan:
- Basic read: mem[0x010+i] = 0x1100+i; base=0x010, stride=1, length=4, out_ready=1.
  - out_data is 0x1100..0x1103 in cycles 3..6; out_last in cycle 6; done in cycle 7; exactly 4 chipselect cycles.
- Wrap and stride:
  - base=0xFFE, stride=1, length=4: addresses are 0xFFE, 0xFFF, 0x000, 0x001.
  - base=0x000, stride=0x040, length=3: addresses are 0x000, 0x040, 0x080.
  - In both cases data matches memory in order.
- Backpressure: length=16, out_ready low for cycles 2..12, then high.
  - No more than 4 reads issued before the first pop.
  - All 16 words arrive in order, no duplicates, out_last only on word 16.
- Zero length: start with length=0.
  - done pulses in cycle 1; busy never high; sram_chipselect never high; out_valid never high.
- Ignored start: start pulsed again mid-transfer with different base/length.
  - The original transfer completes unchanged; there is exactly one done pulse.
- Reset mid-transfer: reset asserted for 1 cycle during RUN of a length=8 transfer.
  - Next cycle: out_valid=0, busy=0, FIFO empty; no done pulse.
  - A fresh start afterwards completes correctly.
